// File: rtl/cp0_pkg.sv
// Shared register map, field positions and exception codes for the CP0 controller.
package cp0_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   localparam int SR_IE    = 0;
   localparam int SR_EXL   = 1;
   localparam int IP_LSB   = 8;
   localparam int EXC_LSB  = 2;
   localparam int CAUSE_BD = 31;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // Return address for a taken event: back up to the branch when the victim is in a delay slot.
   function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
      logic [31:0] t;
      t = bd ? (pc - 32'd4) : pc;
      return {t[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/cp0_ctrl_irq_sampler.sv
// Interrupt line capture: either a plain per-edge mirror of the lines, or rising-edge
// sticky bits that software clears by writing 0.
module irq_sampler #(
   parameter int IRQ_NUM  = 6,
   parameter int IRQ_EDGE = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IRQ_NUM-1:0] irq,
   input  logic               clr_en,
   input  logic [IRQ_NUM-1:0] clr_data,
   output logic [IRQ_NUM-1:0] ip
);

   generate
      if (IRQ_EDGE != 0) begin : g_edge
         logic [IRQ_NUM-1:0] irq_prev;

         // Latch rising edges; a new edge on the same cycle as a software clear wins.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               irq_prev <= '0;
               ip       <= '0;
            end else begin
               irq_prev <= irq;
               ip       <= (clr_en ? (ip & clr_data) : ip) | (irq & ~irq_prev);
            end
         end
      end else begin : g_level
         logic unused_clr;
         assign unused_clr = clr_en ^ (^clr_data);

         // Level mode simply registers the lines; software cannot touch IP.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) ip <= '0;
            else       ip <= irq;
         end
      end
   endgenerate

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 controller: SR/Cause/EPC/PRId, interrupt vs. exception arbitration and eret target.
module cp0_ctrl
   import cp0_pkg::*;
#(
   parameter int          IRQ_NUM  = 6,
   parameter int          IRQ_EDGE = 0,
   parameter logic [31:0] PRID     = 32'h0000_2021
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IRQ_NUM-1:0] irq,
   input  logic               exc_valid,
   input  logic [4:0]         exc_code,
   input  logic [31:0]        pc_in,
   input  logic               bd_in,
   input  logic               eret,
   input  logic               wr_en,
   input  logic [4:0]         wr_addr,
   input  logic [31:0]        wr_data,
   input  logic [4:0]         rd_addr,
   output logic [31:0]        rd_data,
   output logic               req,
   output logic               int_resp,
   output logic [31:0]        epc_out
);

   logic [IRQ_NUM-1:0] im;
   logic [IRQ_NUM-1:0] ip;
   logic               exl;
   logic               ie;
   logic               bd;
   logic [4:0]         exc_code_r;
   logic [31:0]        epc;
   logic               int_pend;
   logic               exc_pend;
   logic               wr_sr;
   logic               wr_epc;
   logic               wr_cause;
   logic [31:0]        sr_word;
   logic [31:0]        cause_word;

   assign wr_sr    = wr_en && (wr_addr == REG_SR);
   assign wr_epc   = wr_en && (wr_addr == REG_EPC);
   // An mtc0 on the same cycle as a taken event belongs to a flushed instruction.
   assign wr_cause = wr_en && (wr_addr == REG_CAUSE) && !req;

   assign int_pend = (|(ip & im)) & ie & ~exl;
   assign exc_pend = exc_valid & ~exl;
   assign req      = ~reset & (int_pend | exc_pend) & ~eret;
   assign int_resp = ~reset & int_pend & ~eret;
   assign epc_out  = wr_epc ? wr_data : epc;

   irq_sampler #(
      .IRQ_NUM  (IRQ_NUM),
      .IRQ_EDGE (IRQ_EDGE)
   ) u_irq_sampler (
      .clk      (clk),
      .reset    (reset),
      .irq      (irq),
      .clr_en   (wr_cause),
      .clr_data (wr_data[IP_LSB +: IRQ_NUM]),
      .ip       (ip)
   );

   // Assemble architectural register views and the mfc0 read mux.
   always_comb begin
      sr_word                      = '0;
      sr_word[IP_LSB +: IRQ_NUM]   = im;
      sr_word[SR_EXL]              = exl;
      sr_word[SR_IE]               = ie;
      cause_word                   = '0;
      cause_word[CAUSE_BD]         = bd;
      cause_word[IP_LSB +: IRQ_NUM] = ip;
      cause_word[EXC_LSB +: 5]     = exc_code_r;
      case (rd_addr)
         REG_SR:    rd_data = sr_word;
         REG_CAUSE: rd_data = cause_word;
         REG_EPC:   rd_data = epc;
         REG_PRID:  rd_data = PRID;
         default:   rd_data = '0;
      endcase
   end

   // Taken events capture context and raise EXL; otherwise apply mtc0 and eret.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im         <= '0;
         exl        <= 1'b0;
         ie         <= 1'b0;
         bd         <= 1'b0;
         exc_code_r <= '0;
         epc        <= '0;
      end else if (req) begin
         exl        <= 1'b1;
         bd         <= bd_in;
         epc        <= epc_target(pc_in, bd_in);
         exc_code_r <= int_resp ? EXC_INT : exc_code;
      end else begin
         if (wr_sr) begin
            im  <= wr_data[IP_LSB +: IRQ_NUM];
            exl <= wr_data[SR_EXL];
            ie  <= wr_data[SR_IE];
         end
         if (wr_epc) epc <= wr_data;
         if (eret)   exl <= 1'b0;
      end
   end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Parametrised coprocessor-0 controller for the five-stage pipelined CPU. It owns SR, Cause, EPC and PRId, and samples up to 8 external interrupt lines in either level or edge-latched mode. It arbitrates interrupts against synchronous exceptions from the pipeline and produces the single-cycle take-exception request and the `eret` return target. It sits beside the M stage: the pipeline presents the faulting or victim instruction's PC and flags here, and the flush/redirect logic consumes `req` and `epc_out`.

## Interface
Parameters:
- `IRQ_NUM`, 6: number of external interrupt lines, legal range 1..8; maps to IP/IM bits [8+IRQ_NUM-1:8].
- `IRQ_EDGE`, 0: 0 = level mode (IP mirrors lines); 1 = edge-latched sticky mode.
- `PRID`, 32'h0000_2021: read-only PRId value.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `irq` in IRQ_NUM: external interrupt lines.
- `exc_valid` in 1: instruction at M has a synchronous exception.
- `exc_code` in 5: ExcCode of that exception.
- `pc_in` in 32: PC of the instruction at M, or of the next valid instruction if M is a bubble.
- `bd_in` in 1: that instruction sits in a delay slot.
- `eret` in 1: `eret` at M.
- `wr_en` in 1: mtc0 write enable.
- `wr_addr` in 5: mtc0 register number.
- `wr_data` in 32: mtc0 write data.
- `rd_addr` in 5: mfc0 register number.
- `rd_data` out 32: combinational read data.
- `req` out 1: take exception/interrupt this cycle (flush and redirect to handler).
- `int_resp` out 1: `req` caused by an interrupt.
- `epc_out` out 32: `eret` target.

## Operation
- Registers:
  - SR (12): IM[8+IRQ_NUM-1:8], EXL[1], IE[0].
  - Cause (13): BD[31], IP[8+IRQ_NUM-1:8], ExcCode[6:2].
  - EPC (14): 32 bits.
  - PRId (15): constant PRID.
  - All other bits and addresses read 0; writes to them are ignored.
- IP update, every edge:
  - Level mode: IP <= irq.
  - Edge mode: IP bit set when irq rises (previous-sample register); cleared by mtc0 Cause writing 0 to that bit. A set on the same edge beats the clear.
- Write access: mtc0 writes SR IM/EXL/IE and all 32 bits of EPC. It writes Cause IP only in edge mode. Cause BD and ExcCode are not software-writable.
- Pending terms:
  - int_pend = |(IP & IM) & IE & ~EXL.
  - exc_pend = exc_valid & ~EXL.
- Request outputs:
  - req = (int_pend | exc_pend) & ~eret.
  - int_resp = int_pend & ~eret. Interrupt has priority over exception.
- On an edge with req=1:
  - EXL <= 1, BD <= bd_in.
  - EPC <= (bd_in ? pc_in-4 : pc_in) with [1:0] forced 0.
  - ExcCode <= int_resp ? 0 : exc_code.
  - A concurrent mtc0 is dropped; that instruction is being flushed.
- On an edge with eret=1: EXL <= 0.
- `epc_out` = (wr_en && wr_addr==14) ? wr_data : EPC. This forwards an mtc0 EPC write to a same-cycle `eret`.
- `rd_data` returns current register contents, not the values being written this edge.

## Timing
- Reset values: SR=0, Cause=0, EPC=0, edge history=0.
- While `reset` is high, `req`=0 and `int_resp`=0. `rd_data` and `epc_out` follow the reset register values.
- Latencies:
  - irq → IP visible: 1 edge.
  - irq → req: combinational in the cycle after that edge, so 1 cycle total.
  - exc_valid → req: 0 cycles (combinational).
- `req` is high for exactly one cycle per event: EXL masks further events from the next edge.
- Simultaneous events:
  - eret with a pending interrupt: eret wins and req=0. The interrupt is taken the cycle after, once EXL=0.
  - Interrupt with exc_valid: ExcCode=0 and EPC=pc_in; the exception is re-raised on return.
  - Reset mid-handler: all state clears asynchronously, and pending edge-mode bits are lost.

## Structure
- `cp0_pkg` holds:
  - Register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - Field bit positions.
  - ExcCodes: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- One sub-module, `irq_sampler`: IRQ_NUM-wide level/edge capture with a write-0-clear input. Outputs IP.

## Test plan
- Level mode, SR=32'h0000_0401, irq[2] raised at cycle 10 with pc_in=32'h3008, bd_in=0:
  - req=1 and int_resp=1 at cycle 11 only.
  - Then Cause=32'h0000_0400, EPC=32'h3008, SR.EXL=1.
- exc_valid=1, exc_code=12, pc_in=32'h3010, bd_in=1:
  - req=1, int_resp=0.
  - EPC=32'h300C, Cause=32'h8000_0030.
  - A second exc_valid the next cycle gives req=0.
- Edge mode, irq[0] held as a 1-cycle pulse:
  - IP[8] stays set after the pulse.
  - mtc0 Cause=0 clears it.
  - A rising edge on the same cycle as the clear leaves it set.
- EXL=1, interrupt pending, eret asserted:
  - req=0 that cycle.
  - req=1 the following cycle.
  - epc_out=EPC.
- mtc0 EPC=32'h4000 and eret in the same cycle: epc_out=32'h4000.
- Async reset asserted mid-cycle during EXL=1:
  - All registers and outputs are 0 immediately.
  - mfc0 15 returns PRID.
